// File: rtl/philo_monitor.sv
// Passive checker for the dining-philosophers ring: flags adjacent eaters, illegal
// state transitions and starvation, and tracks meal count and worst hunger wait.
module philo_monitor #(
  parameter int N        = 32,
  parameter int WAIT_W   = 8,
  parameter int WAIT_MAX = 255,
  parameter int MEAL_W   = 16,
  localparam int IW      = $clog2(N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2*N-1:0]    st_bus,
  output logic              excl_err,
  output logic [IW-1:0]     excl_idx,
  output logic              trans_err,
  output logic [IW-1:0]     trans_idx,
  output logic              starve,
  output logic [IW-1:0]     starve_idx,
  output logic [MEAL_W-1:0] meals_total,
  output logic [WAIT_W-1:0] max_wait
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = MEAL_W + CW;

  typedef enum logic [1:0] {
    ST_THINK  = 2'd0,
    ST_READ   = 2'd1,
    ST_EAT    = 2'd2,
    ST_HUNGRY = 2'd3
  } phil_st_e;

  logic [2*N-1:0]    prev_st_r;
  logic              have_prev_r;
  logic [WAIT_W-1:0] wait_r     [N];
  logic [WAIT_W-1:0] wait_nxt_s [N];
  logic [N-1:0]      excl_v_s;
  logic [N-1:0]      trans_v_s;
  logic [N-1:0]      starve_v_s;
  logic [N-1:0]      enter_v_s;
  logic [WAIT_W-1:0] peak_s;
  logic [CW-1:0]     entries_s;
  logic [SW-1:0]     meal_sum_s;
  logic [MEAL_W-1:0] meals_nxt_s;

  function automatic logic legal_tr(input logic [1:0] p, input logic [1:0] c);
    logic ok;
    case (p)
      ST_READ:   ok = (c == ST_READ) || (c == ST_THINK);
      ST_THINK:  ok = (c != ST_EAT);
      ST_EAT:    ok = (c == ST_EAT) || (c == ST_THINK);
      ST_HUNGRY: ok = (c == ST_HUNGRY) || (c == ST_EAT);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Ties always resolve to the lowest set position.
  function automatic logic [IW-1:0] first_idx(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  // Per-philosopher checks on the current sample and next-state statistics.
  always_comb begin
    peak_s    = {WAIT_W{1'b0}};
    entries_s = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      excl_v_s[i]  = (st_bus[2*i +: 2] == ST_EAT) && (st_bus[2*((i + 1) % N) +: 2] == ST_EAT);
      trans_v_s[i] = have_prev_r && !legal_tr(prev_st_r[2*i +: 2], st_bus[2*i +: 2]);
      enter_v_s[i] = have_prev_r && (prev_st_r[2*i +: 2] != ST_EAT) && (st_bus[2*i +: 2] == ST_EAT);
      wait_nxt_s[i] = (st_bus[2*i +: 2] != ST_HUNGRY) ? {WAIT_W{1'b0}} :
                      (wait_r[i] == {WAIT_W{1'b1}})  ? wait_r[i] : wait_r[i] + WAIT_W'(1);
      starve_v_s[i] = (wait_nxt_s[i] >= WAIT_W'(WAIT_MAX));
      peak_s        = (wait_nxt_s[i] > peak_s) ? wait_nxt_s[i] : peak_s;
      entries_s     = entries_s + CW'(enter_v_s[i]);
    end
    meal_sum_s  = SW'(meals_total) + SW'(entries_s);
    meals_nxt_s = (meal_sum_s > SW'({MEAL_W{1'b1}})) ? {MEAL_W{1'b1}} : meal_sum_s[MEAL_W-1:0];
  end

  // Sticky flags latch their index only on first rise; everything clears on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_st_r   <= {(2*N){1'b0}};
      have_prev_r <= 1'b0;
      for (int i = 0; i < N; i++) wait_r[i] <= {WAIT_W{1'b0}};
      excl_err    <= 1'b0;
      excl_idx    <= {IW{1'b0}};
      trans_err   <= 1'b0;
      trans_idx   <= {IW{1'b0}};
      starve      <= 1'b0;
      starve_idx  <= {IW{1'b0}};
      meals_total <= {MEAL_W{1'b0}};
      max_wait    <= {WAIT_W{1'b0}};
    end else begin
      prev_st_r   <= st_bus;
      have_prev_r <= 1'b1;
      wait_r      <= wait_nxt_s;
      if (|excl_v_s && !excl_err) begin
        excl_err <= 1'b1;
        excl_idx <= first_idx(excl_v_s);
      end
      if (|trans_v_s && !trans_err) begin
        trans_err <= 1'b1;
        trans_idx <= first_idx(trans_v_s);
      end
      if (|starve_v_s && !starve) begin
        starve     <= 1'b1;
        starve_idx <= first_idx(starve_v_s);
      end
      meals_total <= meals_nxt_s;
      max_wait    <= (peak_s > max_wait) ? peak_s : max_wait;
    end
  end

endmodule

// File: tb/tb_philo_monitor.sv
// Table-driven bench for philo_monitor; expectations travel through a queue and are
// checked one cycle after the matching sample is applied.
module tb_philo_monitor;

  localparam logic [1:0] T = 2'd0, R = 2'd1, E = 2'd2, H = 2'd3;

  typedef struct {
    logic        rst;
    logic [63:0] st;
    logic        ex;
    logic [4:0]  ex_idx;
    logic        tr;
    logic [4:0]  tr_idx;
    logic        sv;
    logic [4:0]  sv_idx;
    logic [15:0] meals;
    logic [7:0]  mw;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] st_bus = 64'd0;

  logic        a_ex, a_tr, a_sv, b_ex, b_tr, b_sv;
  logic [4:0]  a_exi, a_tri, a_svi, b_exi, b_tri, b_svi;
  logic [15:0] a_meals;
  logic [1:0]  b_meals;
  logic [7:0]  a_mw, b_mw;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  philo_monitor #(.N(32), .WAIT_W(8), .WAIT_MAX(4), .MEAL_W(16)) u_a (
    .clock(clock), .reset(reset), .st_bus(st_bus),
    .excl_err(a_ex), .excl_idx(a_exi), .trans_err(a_tr), .trans_idx(a_tri),
    .starve(a_sv), .starve_idx(a_svi), .meals_total(a_meals), .max_wait(a_mw));

  philo_monitor #(.N(32), .WAIT_W(8), .WAIT_MAX(4), .MEAL_W(2)) u_b (
    .clock(clock), .reset(reset), .st_bus(st_bus),
    .excl_err(b_ex), .excl_idx(b_exi), .trans_err(b_tr), .trans_idx(b_tri),
    .starve(b_sv), .starve_idx(b_svi), .meals_total(b_meals), .max_wait(b_mw));

  always #5 clock = ~clock;

  function automatic logic [63:0] st3(input int a, input logic [1:0] sa,
                                      input int b, input logic [1:0] sb,
                                      input int c, input logic [1:0] sc);
    logic [63:0] s;
    s = 64'd0;
    if (a >= 0) s[2*a +: 2] = sa;
    if (b >= 0) s[2*b +: 2] = sb;
    if (c >= 0) s[2*c +: 2] = sc;
    return s;
  endfunction

  function automatic vec_t mk(input logic r, input logic [63:0] s, input logic ex, input int exi,
                              input logic tr, input int tri_n, input logic sv, input int svi,
                              input int meals, input int mw);
    vec_t v;
    v.rst = r; v.st = s;
    v.ex = ex; v.ex_idx = 5'(exi);
    v.tr = tr; v.tr_idx = 5'(tri_n);
    v.sv = sv; v.sv_idx = 5'(svi);
    v.meals = 16'(meals); v.mw = 8'(mw);
    return v;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL step %0d %s: got %0h, expected %0h", k, nm, act, req);
  endtask

  task automatic step(input vec_t v, input int k);
    vec_t e;
    logic [15:0] m2;
    reset = v.rst;
    st_bus = v.st;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    m2 = (e.meals > 16'd3) ? 16'd3 : e.meals;
    chk("excl_err",    k, 32'(a_ex),    32'(e.ex));
    chk("excl_idx",    k, 32'(a_exi),   32'(e.ex_idx));
    chk("trans_err",   k, 32'(a_tr),    32'(e.tr));
    chk("trans_idx",   k, 32'(a_tri),   32'(e.tr_idx));
    chk("starve",      k, 32'(a_sv),    32'(e.sv));
    chk("starve_idx",  k, 32'(a_svi),   32'(e.sv_idx));
    chk("meals_total", k, 32'(a_meals), 32'(e.meals));
    chk("max_wait",    k, 32'(a_mw),    32'(e.mw));
    chk("b_excl_err",  k, 32'(b_ex),    32'(e.ex));
    chk("b_excl_idx",  k, 32'(b_exi),   32'(e.ex_idx));
    chk("b_trans_err", k, 32'(b_tr),    32'(e.tr));
    chk("b_trans_idx", k, 32'(b_tri),   32'(e.tr_idx));
    chk("b_starve",    k, 32'(b_sv),    32'(e.sv));
    chk("b_starve_idx",k, 32'(b_svi),   32'(e.sv_idx));
    chk("b_meals_sat", k, 32'(b_meals), 32'(m2));
    chk("b_max_wait",  k, 32'(b_mw),    32'(e.mw));
  endtask

  initial begin
    int m;
    // Quiet ring after reset
    tbl.push_back(mk(1'b1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1'b0, st3(0, R, -1, T, -1, T), 0, 0, 0, 0, 0, 0, 0, 0));
    // Adjacent eaters 3/4, with ph4 jumping THINKING->EATING
    tbl.push_back(mk(1'b0, st3(0, R, 3, H, -1, T), 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1'b0, st3(0, R, 3, E, 4, E), 1, 3, 1, 4, 0, 0, 2, 1));
    tbl.push_back(mk(1'b0, st3(0, R, 3, E, -1, T), 1, 3, 1, 4, 0, 0, 2, 1));
    tbl.push_back(mk(1'b0, st3(0, R, -1, T, -1, T), 1, 3, 1, 4, 0, 0, 2, 1));
    // Wrap pair (31, 0)
    tbl.push_back(mk(1'b1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, st3(31, H, 0, H, -1, T), 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1'b0, st3(31, E, 0, E, -1, T), 1, 31, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(1'b0, 64'd0, 1, 31, 0, 0, 0, 0, 2, 1));
    // Starvation of ph5 at WAIT_MAX=4
    tbl.push_back(mk(1'b0, st3(5, H, -1, T, -1, T), 1, 31, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(1'b0, st3(5, H, -1, T, -1, T), 1, 31, 0, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1'b0, st3(5, H, -1, T, -1, T), 1, 31, 0, 0, 0, 0, 2, 3));
    tbl.push_back(mk(1'b0, st3(5, H, -1, T, -1, T), 1, 31, 0, 0, 1, 5, 2, 4));
    tbl.push_back(mk(1'b0, st3(5, E, -1, T, -1, T), 1, 31, 0, 0, 1, 5, 3, 4));
    tbl.push_back(mk(1'b0, 64'd0, 1, 31, 0, 0, 1, 5, 3, 4));
    // All flags set, then reset; first post-reset sample is not transition-checked
    tbl.push_back(mk(1'b0, st3(8, E, -1, T, -1, T), 1, 31, 1, 8, 1, 5, 4, 4));
    tbl.push_back(mk(1'b1, st3(8, E, -1, T, -1, T), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, st3(7, E, -1, T, -1, T), 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, st3(7, E, -1, T, -1, T), 0, 0, 1, 7, 0, 0, 1, 0));
    // Five legal meals on ph10; the MEAL_W=2 instance saturates at 3
    tbl.push_back(mk(1'b1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    m = 0;
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1'b0, st3(10, H, -1, T, -1, T), 0, 0, 0, 0, 0, 0, m, 1));
      m++;
      tbl.push_back(mk(1'b0, st3(10, E, -1, T, -1, T), 0, 0, 0, 0, 0, 0, m, 1));
      tbl.push_back(mk(1'b0, 64'd0, 0, 0, 0, 0, 0, 0, m, 1));
    end

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Long hunger on ph2 and ph20: tie goes to 2, counter saturates at 255
    step(mk(1'b1, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0), 1000);
    step(mk(1'b0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0), 1001);
    for (int k = 1; k <= 300; k++)
      step(mk(1'b0, st3(2, H, 20, H, -1, T), 0, 0, 0, 0, (k >= 4), (k >= 4) ? 2 : 0, 0,
              (k < 255) ? k : 255), 1001 + k);
    step(mk(1'b0, st3(2, E, 20, E, -1, T), 0, 0, 0, 0, 1, 2, 2, 255), 1400);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
